io_ctrl: RTL and testbench

- Sequences the processor's user I/O resource: the `in` instruction's switch capture and the `out` instruction's display latch.
- Sits between the multicycle control unit and the board pins.
- Synchronises and debounces the raw `enter` button and hands the control unit a one-cycle `in_valid` with a stable captured word.
- Latches `out` data into a held display register and acknowledges the write.

---
 rtl/io_ctrl_if.sv | 33 +++
 rtl/io_ctrl.sv | 94 +++++++++
 tb/tb_io_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_ctrl_if.sv
// Control-unit side of the user I/O block: input-instruction request/capture
// and output-instruction strobe/acknowledge.
interface io_ctrl_if #(
  parameter int DATA_W = 32
) ();
  // req_in is a level held while the control unit waits; in_valid pulses once
  // with in_data stable. req_out is a one-cycle strobe with out_data; out_ack
  // pulses the following cycle. Neither side applies backpressure.
  logic              req_in;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              req_out;
  logic [DATA_W-1:0] out_data;
  logic              out_ack;

  modport master (
    output req_in,
    output req_out,
    output out_data,
    input  in_data,
    input  in_valid,
    input  out_ack
  );

  modport slave (
    input  req_in,
    input  req_out,
    input  out_data,
    output in_data,
    output in_valid,
    output out_ack
  );
endinterface

// File: rtl/io_ctrl.sv
// User I/O sequencer: synchronises and debounces the enter button for the
// `in` instruction and latches `out` data into the display register.
module io_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  io_ctrl_if.slave          cu,
  input  logic [SW_W-1:0]   switches,
  input  logic              enter,
  output logic              waiting,
  output logic [DATA_W-1:0] display,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] DEBOUNCE     = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  localparam int              CNT_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign waiting   = (state == WAIT_PRESS) || (state == DEBOUNCE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      cu.in_data  <= '0;
      cu.in_valid <= 1'b0;
    end else begin
      s1          <= enter;
      s2          <= s1;
      cu.in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cu.req_in) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!cu.req_in) begin
            state <= IDLE;
          end else if (s2) begin
            state <= DEBOUNCE;
            cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!cu.req_in) begin
            state <= IDLE;
          end else if (!s2) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= WAIT_RELEASE;
            cu.in_data  <= DATA_W'(switches);
            cu.in_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A held button must be released before another press is accepted.
        WAIT_RELEASE: begin
          if (!s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output path runs independently of the input FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      display    <= '0;
      cu.out_ack <= 1'b0;
    end else if (cu.req_out) begin
      display    <= cu.out_data;
      cu.out_ack <= 1'b1;
    end else begin
      cu.out_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl: stimulus pushes expected captures/display writes
// into queues; monitors pop and compare when in_valid / out_ack appear.
module tb_io_ctrl;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switches;
  logic        enter;
  logic        waiting;
  logic [31:0] display;
  logic [1:0]  state_dbg;
  int          cyc = 0;

  io_ctrl_if #(.DATA_W(32)) bus ();

  io_ctrl #(.DATA_W(32), .SW_W(16), .DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cu        (bus.slave),
    .switches  (switches),
    .enter     (enter),
    .waiting   (waiting),
    .display   (display),
    .state_dbg (state_dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] exp_out_q[$];
  int          exp_out_cyc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_in(input logic [31:0] data, input int at_cyc);
    exp_q.push_back(data);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic expect_out(input logic [31:0] data, input int at_cyc);
    exp_out_q.push_back(data);
    exp_out_cyc_q.push_back(at_cyc);
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && bus.in_valid) begin
      if (exp_q.size() == 0) begin
        check("in_valid_unexpected", 32'(bus.in_valid), 32'd0);
      end else begin
        logic [31:0] d;
        int          c;
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("in_data", bus.in_data, d);
        check("in_valid_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_ack) begin
      if (exp_out_q.size() == 0) begin
        check("out_ack_unexpected", 32'(bus.out_ack), 32'd0);
      end else begin
        logic [31:0] d;
        int          c;
        d = exp_out_q.pop_front();
        c = exp_out_cyc_q.pop_front();
        check("display", display, d);
        check("out_ack_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  // Driver
  initial begin
    int c;
    rst          = 1'b1;
    enter        = 1'b1;
    switches     = 16'h0000;
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b1;
    bus.out_data = 32'h12345678;

    // Reset wins over enter and req_out
    step(2);
    check("rst_display", display, 32'd0);
    check("rst_in_valid", 32'(bus.in_valid), 32'd0);
    check("rst_out_ack", 32'(bus.out_ack), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    check("rst_in_data", bus.in_data, 32'd0);
    rst         = 1'b0;
    enter       = 1'b0;
    bus.req_out = 1'b0;
    step(1);
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("post_rst_out_ack", 32'(bus.out_ack), 32'd0);

    // Clean press
    bus.req_in = 1'b1;
    switches   = 16'h00A5;
    step(1);
    check("clean_wait_state", 32'(state_dbg), 32'(ST_WAIT_PRESS));
    c     = cyc;
    enter = 1'b1;
    expect_in(32'h000000A5, c + 7);
    step(6);
    check("clean_waiting_before", 32'(waiting), 32'd1);
    step(1);
    check("clean_waiting_after", 32'(waiting), 32'd0);
    bus.req_in = 1'b0;
    step(2);
    enter = 1'b0;
    step(4);
    check("clean_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("in_data_held", bus.in_data, 32'h000000A5);

    // Bounce: high 2, low 1, then held
    bus.req_in = 1'b1;
    switches   = 16'h1234;
    step(1);
    c     = cyc;
    enter = 1'b1;
    step(2);
    enter = 1'b0;
    step(1);
    enter = 1'b1;
    expect_in(32'h00001234, c + 10);
    step(12);
    bus.req_in = 1'b0;
    enter      = 1'b0;
    step(4);
    check("bounce_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Held button is not re-accepted until released
    bus.req_in = 1'b1;
    switches   = 16'hBEEF;
    step(1);
    c     = cyc;
    enter = 1'b1;
    expect_in(32'h0000BEEF, c + 7);
    step(7);
    bus.req_in = 1'b0;
    step(2);
    bus.req_in = 1'b1;
    step(10);
    check("held_wait_release", 32'(state_dbg), 32'(ST_WAIT_RELEASE));
    switches = 16'h0F0F;
    enter    = 1'b0;
    step(4);
    check("held_rearmed", 32'(state_dbg), 32'(ST_WAIT_PRESS));
    c     = cyc;
    enter = 1'b1;
    expect_in(32'h00000F0F, c + 7);
    step(8);
    bus.req_in = 1'b0;
    enter      = 1'b0;
    step(4);
    check("held_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Abort during debounce with cnt=2
    bus.req_in = 1'b1;
    switches   = 16'h5555;
    step(1);
    enter = 1'b1;
    step(5);
    check("abort_debounce", 32'(state_dbg), 32'(ST_DEBOUNCE));
    bus.req_in = 1'b0;
    step(1);
    check("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_waiting", 32'(waiting), 32'd0);
    check("abort_in_valid", 32'(bus.in_valid), 32'd0);
    enter = 1'b0;
    step(4);

    // Output strobe during an active debounce
    bus.req_in = 1'b1;
    switches   = 16'h00C3;
    step(1);
    c     = cyc;
    enter = 1'b1;
    expect_in(32'h000000C3, c + 7);
    step(4);
    check("out_during_debounce", 32'(state_dbg), 32'(ST_DEBOUNCE));
    bus.req_out  = 1'b1;
    bus.out_data = 32'hDEADBEEF;
    expect_out(32'hDEADBEEF, c + 5);
    step(1);
    bus.req_out  = 1'b0;
    bus.out_data = 32'h0;
    step(1);
    check("out_ack_one_cycle", 32'(bus.out_ack), 32'd0);
    step(3);
    check("display_held", display, 32'hDEADBEEF);

    // Back-to-back strobes
    bus.req_out  = 1'b1;
    bus.out_data = 32'h11111111;
    expect_out(32'h11111111, cyc + 1);
    step(1);
    bus.out_data = 32'h22222222;
    expect_out(32'h22222222, cyc + 1);
    step(1);
    bus.req_out = 1'b0;
    step(3);
    check("display_b2b_held", display, 32'h22222222);
    bus.req_in = 1'b0;
    enter      = 1'b0;
    step(5);

    check("in_queue_drained", 32'(exp_q.size()), 32'd0);
    check("out_queue_drained", 32'(exp_out_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
